input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions a raw, asynchronous, bouncing input (push-button or external strobe) into a clean, clock-synchronous level plus single-cycle edge pulses. It sits directly upstream of the sequence-detector FSM: `db_out` drives the detector's `in` input, so the detector sees exactly one clean transition per physical press or release. It also keeps a wrapping count of accepted presses for debug readout.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronized samples at the new level, after the first one, needed to accept a transition. Legal range 1 ≤ STABLE_CYCLES ≤ 2^CNT_W − 1.
- `CNT_W`, default 3: width of the stability counter.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `raw_in` input 1: unsynchronized raw input.
- `db_out` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse when `db_out` goes 0→1, registered.
- `fall` output 1: one-cycle pulse when `db_out` goes 1→0, registered.
- `press_count` output 8: count of accepted rising transitions, registered, wraps.

## Operation
- **Synchronizer:** two flops, `s1 <= raw_in` and `s2 <= s1`. The FSM uses only `s2`.
- **FSM state `LOW` (2'b00):**
  - If `s2`=1: go to `ARM_HIGH`, `cnt` <= 1.
  - Else stay, `cnt` <= 0.
- **FSM state `ARM_HIGH` (2'b01):**
  - If `s2`=0: go to `LOW`, `cnt` <= 0. No pulse, `db_out` unchanged.
  - Else if `cnt` == STABLE_CYCLES: go to `HIGH`, `db_out` <= 1, `rise` <= 1, `press_count` <= `press_count`+1, `cnt` <= 0.
  - Else `cnt` <= `cnt`+1.
- **FSM state `HIGH` (2'b10):** mirror of `LOW`. If `s2`=0, go to `ARM_LOW` with `cnt` <= 1.
- **FSM state `ARM_LOW` (2'b11):** mirror of `ARM_HIGH`.
  - If `s2`=1: go back to `HIGH`.
  - On `cnt` == STABLE_CYCLES with `s2`=0: go to `LOW`, `db_out` <= 0, `fall` <= 1.
- **Pulse defaults:** `rise` and `fall` are 0 in every cycle except the accepting edge. They are never high together.
- **`press_count` arithmetic:** 8-bit modulo, so 255+1 → 0. It is not affected by `fall` or by rejected glitches.
- **Reset values** (async assert, held while `rst`=1): `s1`=0, `s2`=0, state=`LOW`, `cnt`=0, `db_out`=0, `rise`=0, `fall`=0, `press_count`=0.
- **Reset mid-operation:** any in-progress arm is discarded and no pulse is emitted. After release, a `raw_in` that is already high is re-qualified from scratch through `LOW`→`ARM_HIGH`.
- **Rejection rule:** a glitch shorter than the acceptance window never changes `db_out`. The counter restarts from 1 on the next qualifying sample.

## Timing
- **Acceptance latency:** `raw_in` is first sampled high at edge E0. `s2`=1 is visible to the FSM at E2, and `ARM_HIGH` is entered with `cnt`=1 at E2.
- **When the rising edge is accepted:** with `raw_in` held high through edges E0..E(STABLE_CYCLES+2):
  - `db_out`=1 and `rise`=1 after edge E(STABLE_CYCLES+2).
  - `rise` returns to 0 after E(STABLE_CYCLES+3).
  - For STABLE_CYCLES=4, this is after E6.
- **Falling latency:** symmetric, STABLE_CYCLES+2 edges from the first low sample.
- **Minimum accepted pulse width:** STABLE_CYCLES+1 consecutive high samples of `s2`. Anything shorter is rejected.
- **STABLE_CYCLES=1:** `ARM_HIGH` lasts one cycle (`cnt`=1 matches at once), so latency is 3 edges.
- **Sink contract:** `rise`/`fall` are single-cycle and the downstream stage must sample them every clock. `db_out` changes at most once per STABLE_CYCLES+1 cycles.

## Test plan
- **Clean press (STABLE_CYCLES=4):** `rst` pulse, then `raw_in`=1 from E0 held 20 cycles → `db_out` 0 through E5, 1 after E6; `rise`=1 for exactly the E6–E7 cycle; `press_count`=1; `fall` never asserted.
- **Glitch:** `raw_in`=1 for 3 cycles, then 0 → `db_out` stays 0; `rise`=0 throughout; `press_count`=0; FSM returns to `LOW`.
- **Bounce train:** `raw_in` toggles 1,0,1,1,0,1 then holds 1 → exactly one `rise`, 6 edges after the final rising sample; `press_count`=1. Then a bouncing release → exactly one `fall`; `db_out`=0.
- **Wrap:** 256 clean press/release pairs → `press_count` reads 255 after the 255th press and 0 after the 256th; `rise` count=256, `fall` count=256.
- **Reset mid-arm:** `raw_in`=1, assert `rst` asynchronously at E4 (between edges), hold 2 cycles, release with `raw_in` still 1 → all outputs 0 immediately on assert; `db_out` rises 6 edges after the first post-reset sample; `press_count`=1.
- **Minimum width (STABLE_CYCLES=1):** `raw_in` high for exactly 2 samples → accepted, `rise` after E3. High for 1 sample → rejected.

Source files
------------

// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer_if
//  Description : Signal bundle between a raw input source and the debouncer.
//                The master drives the raw input and receives the cleaned
//                level, edge pulses and press count; the slave is the
//                debouncer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_debouncer_if;

   logic       raw_in;
   logic       db_out;
   logic       rise;
   logic       fall;
   logic [7:0] press_count;

   modport master (
      output raw_in,
      input  db_out,
      input  rise,
      input  fall,
      input  press_count
   );

   modport slave (
      input  raw_in,
      output db_out,
      output rise,
      output fall,
      output press_count
   );

endinterface : input_debouncer_if
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Two-flop synchronizer followed by a four-state qualification
//                FSM. A new level on the synchronized input is accepted only
//                after it has been seen for STABLE_CYCLES+1 consecutive
//                samples; acceptance produces a registered level change, a
//                single-cycle rise/fall pulse and (for rises) an increment of
//                a wrapping 8-bit press counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input_debouncer_if.slave  bus
);

   // ------------------------------------------------------------------------
   // State encoding and counter constants
   // ------------------------------------------------------------------------
   localparam logic [1:0]       c_st_low      = 2'b00;
   localparam logic [1:0]       c_st_arm_high = 2'b01;
   localparam logic [1:0]       c_st_high     = 2'b10;
   localparam logic [1:0]       c_st_arm_low  = 2'b11;

   // STABLE_CYCLES must fit in CNT_W bits; the arm counter compares against
   // this truncated value, so an out-of-range parameter would silently alias.
   localparam logic [CNT_W-1:0] c_cnt_target  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_zero    = '0;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic             r_s1;
   logic             r_s2;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_db;
   logic             r_rise;
   logic             r_fall;
   logic [7:0]       r_press_count;

   // ------------------------------------------------------------------------
   // Combinational next values
   // ------------------------------------------------------------------------
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_acc_rise;
   logic             w_acc_fall;
   logic             w_db_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic [7:0]       w_press_count_nxt;

   // Two-flop synchronizer; only r_s2 is ever looked at by the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= bus.raw_in;
         r_s2 <= r_s1;
      end
   end

   // State register: FSM state, arm counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_st_low;
         r_cnt         <= c_cnt_zero;
         r_db          <= 1'b0;
         r_rise        <= 1'b0;
         r_fall        <= 1'b0;
         r_press_count <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_db          <= w_db_nxt;
         r_rise        <= w_rise_nxt;
         r_fall        <= w_fall_nxt;
         r_press_count <= w_press_count_nxt;
      end
   end

   // Next-state logic: qualify the synchronized input and flag acceptance.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_rise  = 1'b0;
      w_acc_fall  = 1'b0;
      case (r_state)
         c_st_low: begin
            if (r_s2) begin
               w_state_nxt = c_st_arm_high;
               w_cnt_nxt   = c_cnt_one;
            end else begin
               w_cnt_nxt   = c_cnt_zero;
            end
         end
         c_st_arm_high: begin
            if (!r_s2) begin
               // Glitch: drop back without touching the output level.
               w_state_nxt = c_st_low;
               w_cnt_nxt   = c_cnt_zero;
            end else if (r_cnt == c_cnt_target) begin
               w_state_nxt = c_st_high;
               w_cnt_nxt   = c_cnt_zero;
               w_acc_rise  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + c_cnt_one;
            end
         end
         c_st_high: begin
            if (!r_s2) begin
               w_state_nxt = c_st_arm_low;
               w_cnt_nxt   = c_cnt_one;
            end else begin
               w_cnt_nxt   = c_cnt_zero;
            end
         end
         c_st_arm_low: begin
            if (r_s2) begin
               w_state_nxt = c_st_high;
               w_cnt_nxt   = c_cnt_zero;
            end else if (r_cnt == c_cnt_target) begin
               w_state_nxt = c_st_low;
               w_cnt_nxt   = c_cnt_zero;
               w_acc_fall  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = c_st_low;
            w_cnt_nxt   = c_cnt_zero;
         end
      endcase
   end

   // Output logic: turn acceptance flags into level, pulses and press count.
   always_comb begin
      w_db_nxt          = r_db;
      w_rise_nxt        = w_acc_rise;
      w_fall_nxt        = w_acc_fall;
      w_press_count_nxt = r_press_count;
      if (w_acc_rise) begin
         w_db_nxt          = 1'b1;
         w_press_count_nxt = r_press_count + 8'd1;
      end
      if (w_acc_fall) begin
         w_db_nxt = 1'b0;
      end
   end

   assign bus.db_out      = r_db;
   assign bus.rise        = r_rise;
   assign bus.fall        = r_fall;
   assign bus.press_count = r_press_count;

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Directed, self-checking bench for input_debouncer. One
//                instance uses the default STABLE_CYCLES=4, a second uses
//                STABLE_CYCLES=1 for the minimum-width cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

   logic clk;
   logic rst;

   input_debouncer_if ifa ();
   input_debouncer_if ifb ();

   input_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   input_debouncer #(.STABLE_CYCLES(1), .CNT_W(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Pulse monitors, sampled on the falling edge away from register updates.
   int rise_a = 0, fall_a = 0, both_a = 0;
   int rise_b = 0, fall_b = 0, both_b = 0;

   // Count edge pulses of both instances.
   always @(negedge clk) begin
      if (ifa.rise) rise_a++;
      if (ifa.fall) fall_a++;
      if (ifa.rise && ifa.fall) both_a++;
      if (ifb.rise) rise_b++;
      if (ifb.fall) fall_b++;
      if (ifb.rise && ifb.fall) both_b++;
   end

   function automatic logic [31:0] pk(input bit db, input bit r, input bit f, input int pc);
      logic [7:0] p;
      p = pc[7:0];
      return {21'b0, db, r, f, p};
   endfunction

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   function automatic logic [31:0] obs_a();
      return {21'b0, ifa.db_out, ifa.rise, ifa.fall, ifa.press_count};
   endfunction

   function automatic logic [31:0] obs_b();
      return {21'b0, ifb.db_out, ifb.rise, ifb.fall, ifb.press_count};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int base_r;
   int base_f;
   logic [5:0] bounce_hi;
   logic [5:0] bounce_lo;

   initial begin
      rst        = 1'b1;
      ifa.raw_in = 1'b0;
      ifb.raw_in = 1'b0;
      bounce_hi  = 6'b101101;   // bit 5 first: 1,0,1,1,0,1
      bounce_lo  = 6'b010010;   // bit 5 first: 0,1,0,0,1,0

      // Reset state
      ticks(2);
      push("reset_a", pk(0, 0, 0, 0)); pop_chk(obs_a());
      push("reset_b", pk(0, 0, 0, 0)); pop_chk(obs_b());
      rst = 1'b0;
      ticks(3);

      // Clean press: accepted after edge E6, held 20 cycles
      for (int k = 0; k < 20; k++) begin
         ifa.raw_in = 1'b1;
         push($sformatf("clean_press_e%0d", k), pk(k >= 6, k == 6, 0, (k >= 6) ? 1 : 0));
         tick();
         pop_chk(obs_a());
      end

      // Clean release: fall pulse after E6
      for (int k = 0; k < 10; k++) begin
         ifa.raw_in = 1'b0;
         push($sformatf("clean_release_e%0d", k), pk(k < 6, 0, k == 6, 1));
         tick();
         pop_chk(obs_a());
      end

      // Glitch of 3 samples: rejected
      for (int k = 0; k < 12; k++) begin
         ifa.raw_in = (k < 3);
         push($sformatf("glitch_e%0d", k), pk(0, 0, 0, 1));
         tick();
         pop_chk(obs_a());
      end

      // Bounce train 1,0,1,1,0,1 then hold: single rise at E11
      for (int k = 0; k < 16; k++) begin
         ifa.raw_in = (k < 6) ? bounce_hi[5 - k] : 1'b1;
         push($sformatf("bounce_press_e%0d", k), pk(k >= 11, k == 11, 0, (k >= 11) ? 2 : 1));
         tick();
         pop_chk(obs_a());
      end

      // Bouncing release 0,1,0,0,1,0 then hold: single fall at E11
      for (int k = 0; k < 16; k++) begin
         ifa.raw_in = (k < 6) ? bounce_lo[5 - k] : 1'b0;
         push($sformatf("bounce_release_e%0d", k), pk(k < 11, 0, k == 11, 2));
         tick();
         pop_chk(obs_a());
      end

      // Wrap: 256 clean press/release pairs from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("wrap_start", pk(0, 0, 0, 0)); pop_chk(obs_a());
      base_r = rise_a;
      base_f = fall_a;
      for (int i = 1; i <= 256; i++) begin
         ifa.raw_in = 1'b1;
         push($sformatf("wrap_press_%0d", i), pk(1, 0, 0, i % 256));
         ticks(8);
         pop_chk(obs_a());
         ifa.raw_in = 1'b0;
         push($sformatf("wrap_release_%0d", i), pk(0, 0, 0, i % 256));
         ticks(8);
         pop_chk(obs_a());
      end
      push("wrap_rise_count", 32'(256)); pop_chk(32'(rise_a - base_r));
      push("wrap_fall_count", 32'(256)); pop_chk(32'(fall_a - base_f));

      // Reset mid-arm: first get a nonzero press count
      ifa.raw_in = 1'b1;
      ticks(8);
      ifa.raw_in = 1'b0;
      ticks(8);
      push("pre_reset_count", pk(0, 0, 0, 1)); pop_chk(obs_a());
      ifa.raw_in = 1'b1;
      ticks(4);
      #3;
      rst = 1'b1;
      #1;
      push("async_reset_now", pk(0, 0, 0, 0)); pop_chk(obs_a());
      ticks(2);
      push("reset_held", pk(0, 0, 0, 0)); pop_chk(obs_a());
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         push($sformatf("post_reset_e%0d", k), pk(k >= 6, k == 6, 0, (k >= 6) ? 1 : 0));
         tick();
         pop_chk(obs_a());
      end

      // STABLE_CYCLES=1: two high samples accepted after E3, fall after E5
      for (int k = 0; k < 9; k++) begin
         ifb.raw_in = (k < 2);
         push($sformatf("min2_e%0d", k), pk(k >= 3 && k < 5, k == 3, k == 5, (k >= 3) ? 1 : 0));
         tick();
         pop_chk(obs_b());
      end

      // STABLE_CYCLES=1: one high sample rejected
      for (int k = 0; k < 8; k++) begin
         ifb.raw_in = (k < 1);
         push($sformatf("min1_e%0d", k), pk(0, 0, 0, 1));
         tick();
         pop_chk(obs_b());
      end

      // Pulse bookkeeping for the narrow instance and exclusivity of pulses
      push("b_rise_count", 32'(1)); pop_chk(32'(rise_b));
      push("b_fall_count", 32'(1)); pop_chk(32'(fall_b));
      push("a_rise_fall_overlap", 32'(0)); pop_chk(32'(both_a));
      push("b_rise_fall_overlap", 32'(0)); pop_chk(32'(both_b));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_input_debouncer
`default_nettype wire
